// File: rtl/servo_pwm_capture.sv
// Servo PWM high-time capture in whole microseconds, with timeout detection.
// Define PWM_CAPTURE_PERIOD_EN to add rise-to-rise period reporting.
module servo_pwm_capture #(
    parameter int CLK_FREQ_HZ  = 50000000,
    parameter int WIDTH_MIN_US = 500,
    parameter int WIDTH_MAX_US = 2500,
    parameter int TIMEOUT_US   = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [15:0] width_us,
    output logic        width_valid,
    output logic        in_range,
    output logic        timeout
`ifdef PWM_CAPTURE_PERIOD_EN
    ,
    output logic [15:0] period_us,
    output logic        period_valid
`endif
);

    localparam int DIV = CLK_FREQ_HZ / 1000000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);
    localparam logic [15:0]   TMO      = 16'(TIMEOUT_US);
    localparam logic [15:0]   WMIN     = 16'(WIDTH_MIN_US);
    localparam logic [15:0]   WMAX     = 16'(WIDTH_MAX_US);

    typedef enum logic [1:0] {
        SYNC_LOW,
        WAIT_RISE,
        HIGH
    } state_t;

    state_t        state_q, state_d;
    logic          s1_q, s2_q, s3_q;
    logic [PW-1:0] psc_q, psc_d;
    logic [15:0]   wcnt_q, wcnt_d;
    logic [15:0]   per_q, per_d;
    logic [15:0]   width_q, width_d;
    logic          valid_q, valid_d;
    logic          inr_q, inr_d;
    logic          tmo_q, tmo_d;
    logic          rise, fall, tick;
    logic [15:0]   wcnt_inc, per_inc;

    // Synchroniser runs through reset so the FSM sees the true line level.
    always_ff @(posedge clk) begin
        s1_q <= pwm_in;
        s2_q <= s1_q;
        s3_q <= s2_q;
    end

    assign rise     = s2_q & ~s3_q;
    assign fall     = ~s2_q & s3_q;
    assign tick     = (psc_q == PSC_LAST);
    assign wcnt_inc = (tick && wcnt_q != 16'hFFFF) ? wcnt_q + 16'd1 : wcnt_q;
    assign per_inc  = (tick && per_q < TMO) ? per_q + 16'd1 : per_q;

`ifdef PWM_CAPTURE_PERIOD_EN
    logic          have_q, have_d;
    logic [15:0]   pus_q, pus_d;
    logic          pval_q, pval_d;
`endif

    always_comb begin
        state_d = state_q;
        psc_d   = tick ? '0 : psc_q + 1'b1;
        wcnt_d  = wcnt_q;
        per_d   = per_inc;
        width_d = width_q;
        valid_d = 1'b0;
        inr_d   = inr_q;
        tmo_d   = tmo_q;
`ifdef PWM_CAPTURE_PERIOD_EN
        have_d  = have_q;
        pus_d   = pus_q;
        pval_d  = 1'b0;
`endif
        unique case (state_q)
            SYNC_LOW: begin
                if (!s2_q) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    state_d = HIGH;
                    wcnt_d  = '0;
                    per_d   = '0;
                    psc_d   = '0;
`ifdef PWM_CAPTURE_PERIOD_EN
                    // A saturated period means the line was lost.
                    if (have_q && per_inc < TMO) begin
                        pus_d  = per_inc;
                        pval_d = 1'b1;
                    end
                    have_d = 1'b1;
`endif
                end else if (per_q == TMO) begin
                    tmo_d = 1'b1;
`ifdef PWM_CAPTURE_PERIOD_EN
                    have_d = 1'b0;
`endif
                end
            end
            HIGH: begin
                wcnt_d = wcnt_inc;
                if (fall) begin
                    width_d = wcnt_inc;
                    valid_d = 1'b1;
                    inr_d   = (wcnt_inc >= WMIN) && (wcnt_inc <= WMAX);
                    tmo_d   = 1'b0;
                    state_d = WAIT_RISE;
                end else if (per_q == TMO) begin
                    tmo_d   = 1'b1;
                    state_d = SYNC_LOW;
`ifdef PWM_CAPTURE_PERIOD_EN
                    have_d  = 1'b0;
`endif
                end
            end
            default: state_d = SYNC_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= SYNC_LOW;
            psc_q   <= '0;
            wcnt_q  <= '0;
            per_q   <= '0;
            width_q <= '0;
            valid_q <= 1'b0;
            inr_q   <= 1'b0;
            tmo_q   <= 1'b0;
`ifdef PWM_CAPTURE_PERIOD_EN
            have_q  <= 1'b0;
            pus_q   <= '0;
            pval_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            wcnt_q  <= wcnt_d;
            per_q   <= per_d;
            width_q <= width_d;
            valid_q <= valid_d;
            inr_q   <= inr_d;
            tmo_q   <= tmo_d;
`ifdef PWM_CAPTURE_PERIOD_EN
            have_q  <= have_d;
            pus_q   <= pus_d;
            pval_q  <= pval_d;
`endif
        end
    end

    assign width_us    = width_q;
    assign width_valid = valid_q;
    assign in_range    = inr_q;
    assign timeout     = tmo_q;
`ifdef PWM_CAPTURE_PERIOD_EN
    assign period_us    = pus_q;
    assign period_valid = pval_q;
`endif

endmodule

// File: doc/servo_pwm_capture.md
Name: servo_pwm_capture

Overview:
Measures the high-time of one servo-style PWM input in whole microseconds and publishes it with a one-cycle valid strobe. It is the reader-side counterpart to the servo PWM generators driven by the gesture decoder. It is used to loop back or monitor finger servo drive signals and to accept external RC-style commands. One instance per channel; the top level instantiates five.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency; must be an integer multiple of 1000000.
WIDTH_MIN_US, 500, lowest width reported as in range.
WIDTH_MAX_US, 2500, highest width reported as in range.
TIMEOUT_US, 25000, µs without a rising edge (or with input stuck high) before timeout asserts; must be ≤ 65535.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset), sampled on clk
pwm_in  in  1  asynchronous PWM input
width_us  out  16  last completed pulse high-time, µs
width_valid  out  1  one-cycle strobe: width_us updated this cycle
in_range  out  1  WIDTH_MIN_US ≤ width_us ≤ WIDTH_MAX_US, updated with width_us
timeout  out  1  level; signal lost or stuck high

Behaviour:
- Reset values:
  - width_us = 0, width_valid = 0, in_range = 0, timeout = 0.
  - FSM = SYNC_LOW; all counters = 0.
  - Reset asserted mid-pulse aborts the measurement; no strobe is produced.
- Input synchronisation:
  - 2-flop synchroniser on pwm_in, then a registered copy for edge detection.
  - rise/fall are derived from the synchronised signal only.
- µs tick:
  - Prescaler counts 0..DIV-1, with DIV = CLK_FREQ_HZ/1000000.
  - The tick pulses when the prescaler reaches DIV-1.
  - The prescaler is cleared on every detected rise, so the width count is aligned to pulse start.
- Width counter:
  - Cleared on rise; +1 per tick while in HIGH; saturates at 16'hFFFF.
  - Result = floor(high_cycles/DIV). Example: 75000 cycles at 50 MHz → 1500.
- Period counter:
  - Counts ticks in all states; cleared on rise; saturates at TIMEOUT_US.
- FSM states:
  - SYNC_LOW: wait for the synchronised input = 0, which discards any pulse already in progress at reset/abort. Go to WAIT_RISE when it is 0.
  - WAIT_RISE:
    - rise → HIGH, clearing the width counter, period counter and prescaler.
    - period counter reaching TIMEOUT_US → timeout = 1; stay.
  - HIGH:
    - fall → publish on the next edge: width_us ← count, in_range ← compare, width_valid = 1 for exactly one cycle, timeout ← 0. Go to WAIT_RISE.
    - period counter reaching TIMEOUT_US with no fall → timeout = 1, no strobe, go to SYNC_LOW.
- Latency: raw falling edge of pwm_in → width_valid high is 3 clk (2 sync + 1 publish).
- Simultaneous events:
  - fall and timeout in the same cycle (HIGH): the fall wins; the width is published and timeout stays 0.
  - rise and timeout threshold in the same cycle (WAIT_RISE): the rise wins; timeout is not set.
- timeout is sticky. It clears only on the next completed pulse, or on reset.
- width_us/in_range hold their last values between strobes and during timeout.
- Pulses shorter than 1 µs publish width_us = 0, in_range = 0; the strobe still fires.

Optional Feature:
Macro PWM_CAPTURE_PERIOD_EN.
- When defined, adds ports:
  - period_us  out  16: rise-to-rise interval, µs.
  - period_valid  out  1: one-cycle strobe.
- On each rise, period_us ← period counter and period_valid = 1, but only if the previous rise was observed without an intervening reset or timeout.
- The first rise after reset or timeout does not strobe.
- A period that saturates at TIMEOUT_US is never published.
- Reset values: period_us = 0, period_valid = 0.
- When undefined, these ports and the associated logic are absent; all other behaviour is identical.

Test Plan:
1. Release reset. Drive 1500 µs pulses at 20 ms period, 50 MHz → width_valid is one cycle, 3 clk after each raw fall; width_us = 1500, in_range = 1, timeout = 0.
2. Pulses of 400 µs then 2600 µs → width_us = 400 then 2600, in_range = 0 both times; a 500 µs pulse → in_range = 1.
3. Release reset while pwm_in is high (700 µs into the pulse) → no strobe for that pulse; the next 1200 µs pulse → width_us = 1200. Also assert reset mid-pulse → all outputs 0, no strobe.
4. Hold pwm_in low for 30 ms after a pulse → timeout = 1 exactly 25000 µs after the last rise, width_us holds; the next 1600 µs pulse → timeout = 0, width_us = 1600.
5. Hold pwm_in high for 30 ms → timeout = 1 at 25000 µs, no strobe; then low followed by a 1400 µs pulse → width_us = 1400, timeout = 0.
6. With PWM_CAPTURE_PERIOD_EN, 20 ms period → no period_valid on the first rise, then period_us = 20000 on each subsequent rise; after a timeout, the first rise produces no period strobe.
